// File: rtl/bus_fabric_if.sv
// Bundle of bus-source selects, source data and the shared bus value.
// The fabric takes the slave view; whoever drives the selects takes the master view.
interface bus_fabric_if;
  logic        R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out;
  logic        R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out;
  logic        HIout,  LOout,  ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout;

  logic [31:0] BusMuxIn_R0,  BusMuxIn_R1,  BusMuxIn_R2,  BusMuxIn_R3;
  logic [31:0] BusMuxIn_R4,  BusMuxIn_R5,  BusMuxIn_R6,  BusMuxIn_R7;
  logic [31:0] BusMuxIn_R8,  BusMuxIn_R9,  BusMuxIn_R10, BusMuxIn_R11;
  logic [31:0] BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15;
  logic [31:0] BusMuxIn_HI,  BusMuxIn_LO,  BusMuxIn_Zhigh, BusMuxIn_Zlow;
  logic [31:0] BusMuxIn_PC,  BusMuxIn_MDR, BusMuxIn_InPort, C_sign_extended;

  logic [31:0] BusMuxOut;

  modport master (
    output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
           R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
           HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout,
           BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
           BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
           BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
           BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
           BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_Zhigh, BusMuxIn_Zlow,
           BusMuxIn_PC, BusMuxIn_MDR, BusMuxIn_InPort, C_sign_extended,
    input  BusMuxOut
  );

  modport slave (
    input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
           R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
           HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout,
           BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
           BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
           BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
           BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
           BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_Zhigh, BusMuxIn_Zlow,
           BusMuxIn_PC, BusMuxIn_MDR, BusMuxIn_InPort, C_sign_extended,
    output BusMuxOut
  );
endinterface

// File: rtl/bus_fabric.sv
// Shared 32-bit CPU bus: priority-encoded one-hot select driving a 32:1 mux, plus reg32.
// Define BUS_ERR_EN to add the sticky multi-driver flag bus_error.

module reg32 (
  input  logic        clr,
  input  logic        clk,
  input  logic        enable,
  input  logic [31:0] D,
  output logic [31:0] Q
);
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (clr)         Q <= '0;
    else if (enable) Q <= D;
  end
endmodule

module bus_fabric (
  input  logic         clk,
  input  logic         clr,
`ifdef BUS_ERR_EN
  output logic         bus_error,
`endif
  bus_fabric_if.slave  bus
);
  logic [31:0] sel;
  logic [31:0] data [32];
  logic [4:0]  code;
  logic        any_sel;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel     = '0;
    sel[0]  = bus.R0out;    sel[1]  = bus.R1out;    sel[2]  = bus.R2out;
    sel[3]  = bus.R3out;    sel[4]  = bus.R4out;    sel[5]  = bus.R5out;
    sel[6]  = bus.R6out;    sel[7]  = bus.R7out;    sel[8]  = bus.R8out;
    sel[9]  = bus.R9out;    sel[10] = bus.R10out;   sel[11] = bus.R11out;
    sel[12] = bus.R12out;   sel[13] = bus.R13out;   sel[14] = bus.R14out;
    sel[15] = bus.R15out;   sel[16] = bus.HIout;    sel[17] = bus.LOout;
    sel[18] = bus.ZHighOut; sel[19] = bus.ZLowOut;  sel[20] = bus.PCout;
    sel[21] = bus.MDRout;   sel[22] = bus.InPortOut; sel[23] = bus.Cout;
  end

  // Slots 24-31 stay zero so an out-of-range code still yields 0 on the bus.
  always_comb begin
    for (int i = 0; i < 32; i++) data[i] = '0;
    data[0]  = bus.BusMuxIn_R0;    data[1]  = bus.BusMuxIn_R1;
    data[2]  = bus.BusMuxIn_R2;    data[3]  = bus.BusMuxIn_R3;
    data[4]  = bus.BusMuxIn_R4;    data[5]  = bus.BusMuxIn_R5;
    data[6]  = bus.BusMuxIn_R6;    data[7]  = bus.BusMuxIn_R7;
    data[8]  = bus.BusMuxIn_R8;    data[9]  = bus.BusMuxIn_R9;
    data[10] = bus.BusMuxIn_R10;   data[11] = bus.BusMuxIn_R11;
    data[12] = bus.BusMuxIn_R12;   data[13] = bus.BusMuxIn_R13;
    data[14] = bus.BusMuxIn_R14;   data[15] = bus.BusMuxIn_R15;
    data[16] = bus.BusMuxIn_HI;    data[17] = bus.BusMuxIn_LO;
    data[18] = bus.BusMuxIn_Zhigh; data[19] = bus.BusMuxIn_Zlow;
    data[20] = bus.BusMuxIn_PC;    data[21] = bus.BusMuxIn_MDR;
    data[22] = bus.BusMuxIn_InPort; data[23] = bus.C_sign_extended;
  end

  // Scan high to low so the lowest asserted select is the last one written and wins.
  always_comb begin
    code    = '0;
    any_sel = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (sel[i]) begin
        code    = 5'(i);
        any_sel = 1'b1;
      end
    end
  end

  assign bus.BusMuxOut = any_sel ? data[code] : 32'h0000_0000;

`ifdef BUS_ERR_EN
  logic multi_sel;

  // Clearing the lowest set bit leaves something only if two or more selects are high.
  assign multi_sel = |(sel & (sel - 32'd1));

  always_ff @(posedge clk) begin
    if (clr)            bus_error <= 1'b0;
    else if (multi_sel) bus_error <= 1'b1;
  end
`else
  wire unused_clk_clr = clk ^ clr;
`endif
endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric with two reg32 destinations (R0, R1) hanging off the bus.
// bus_error checks are compiled in only when BUS_ERR_EN is defined.
module tb_bus_fabric;
  logic clk = 1'b0;
  logic clr;
  logic en0, en1;
  logic [23:0] sel;
  logic [31:0] din [24];
  logic [31:0] q0, q1;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_fabric_if bus ();

  assign bus.R0out  = sel[0];  assign bus.R1out  = sel[1];  assign bus.R2out  = sel[2];
  assign bus.R3out  = sel[3];  assign bus.R4out  = sel[4];  assign bus.R5out  = sel[5];
  assign bus.R6out  = sel[6];  assign bus.R7out  = sel[7];  assign bus.R8out  = sel[8];
  assign bus.R9out  = sel[9];  assign bus.R10out = sel[10]; assign bus.R11out = sel[11];
  assign bus.R12out = sel[12]; assign bus.R13out = sel[13]; assign bus.R14out = sel[14];
  assign bus.R15out = sel[15]; assign bus.HIout  = sel[16]; assign bus.LOout  = sel[17];
  assign bus.ZHighOut = sel[18]; assign bus.ZLowOut = sel[19]; assign bus.PCout = sel[20];
  assign bus.MDRout = sel[21]; assign bus.InPortOut = sel[22]; assign bus.Cout = sel[23];

  assign bus.BusMuxIn_R0  = din[0];  assign bus.BusMuxIn_R1  = din[1];
  assign bus.BusMuxIn_R2  = din[2];  assign bus.BusMuxIn_R3  = din[3];
  assign bus.BusMuxIn_R4  = din[4];  assign bus.BusMuxIn_R5  = din[5];
  assign bus.BusMuxIn_R6  = din[6];  assign bus.BusMuxIn_R7  = din[7];
  assign bus.BusMuxIn_R8  = din[8];  assign bus.BusMuxIn_R9  = din[9];
  assign bus.BusMuxIn_R10 = din[10]; assign bus.BusMuxIn_R11 = din[11];
  assign bus.BusMuxIn_R12 = din[12]; assign bus.BusMuxIn_R13 = din[13];
  assign bus.BusMuxIn_R14 = din[14]; assign bus.BusMuxIn_R15 = din[15];
  assign bus.BusMuxIn_HI  = din[16]; assign bus.BusMuxIn_LO  = din[17];
  assign bus.BusMuxIn_Zhigh = din[18]; assign bus.BusMuxIn_Zlow = din[19];
  assign bus.BusMuxIn_PC  = din[20]; assign bus.BusMuxIn_MDR = din[21];
  assign bus.BusMuxIn_InPort = din[22]; assign bus.C_sign_extended = din[23];

`ifdef BUS_ERR_EN
  logic bus_error;
  bus_fabric dut (.clk(clk), .clr(clr), .bus_error(bus_error), .bus(bus));
`else
  bus_fabric dut (.clk(clk), .clr(clr), .bus(bus));
`endif

  reg32 r0_reg (.clr(clr), .clk(clk), .enable(en0), .D(bus.BusMuxOut), .Q(q0));
  reg32 r1_reg (.clr(clr), .clk(clk), .enable(en1), .D(bus.BusMuxOut), .Q(q1));

  typedef struct {
    logic [23:0] sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: the bus shows the input of the lowest-numbered asserted select, else zero.
  function automatic logic [31:0] model_bus(input logic [23:0] s);
    int idx [$];
    for (int i = 0; i < 24; i++) if (s[i]) idx.push_back(i);
    if (idx.size() == 0) return 32'h0;
    return din[idx.min()[0]];
  endfunction

  function automatic bit model_multi(input logic [23:0] s);
    return $countones(s) >= 2;
  endfunction

  logic [31:0] m_q0;
  bit          m_err;

  initial begin
    sel = '0; en0 = 0; en1 = 0; clr = 1;
    for (int i = 0; i < 24; i++) din[i] = 32'h0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_r0", q0, 32'h0);
    check("reset_r1", q1, 32'h0);
    check("reset_bus", bus.BusMuxOut, 32'h0);
`ifdef BUS_ERR_EN
    check("reset_err", {31'h0, bus_error}, 32'h0);
`endif

    // Constant load into R0
    @(negedge clk);
    clr = 0; din[23] = 32'hAABB_CCDD; sel = 24'h80_0000; en0 = 1;
    #1 check("const_bus", bus.BusMuxOut, 32'hAABB_CCDD);
    @(posedge clk); #1;
    check("const_r0", q0, 32'hAABB_CCDD);

    // R0 -> R1 transfer
    @(negedge clk);
    din[0] = q0; sel = 24'h00_0001; en0 = 0; en1 = 1;
    @(posedge clk); #1;
    check("xfer_r1", q1, 32'hAABB_CCDD);
    check("xfer_r0", q0, 32'hAABB_CCDD);

    // Drop select and enable together: R1 holds
    @(negedge clk);
    sel = '0; en1 = 0; din[0] = 32'h1234_5678;
    @(posedge clk); #1;
    check("hold_r1", q1, 32'hAABB_CCDD);

    // Table: walking select, no select, priority cases
    for (int i = 0; i < 24; i++) din[i] = 32'(i + 1) * 32'h0101_0101;
    for (int i = 0; i < 24; i++) vecs.push_back('{24'(1) << i, 32'(i + 1) * 32'h0101_0101});
    vecs.push_back('{24'h00_0000, 32'h0000_0000});
    vecs.push_back('{24'h10_0008, 32'h0404_0404});  // R3 + PC
    vecs.push_back('{24'h80_0001, 32'h0101_0101});  // R0 + C
    vecs.push_back('{24'h00_00E0, 32'h0606_0606});  // R5..R7
    vecs.push_back('{24'hC0_0000, 32'h1717_1717});  // InPort + C
    foreach (vecs[k]) begin
      @(negedge clk);
      sel = vecs[k].sel;
      #1 check($sformatf("table%0d", k), bus.BusMuxOut, vecs[k].exp);
    end

`ifdef BUS_ERR_EN
    // Priority/error: R3 + PC sets the flag, which sticks until clr
    @(negedge clk); clr = 1; sel = '0;
    @(negedge clk); clr = 0; sel = 24'h10_0008;
    @(posedge clk); #1;
    check("err_set", {31'h0, bus_error}, 32'h1);
    @(negedge clk); sel = '0;
    repeat (3) @(posedge clk); #1;
    check("err_sticky", {31'h0, bus_error}, 32'h1);
    @(negedge clk); clr = 1; sel = 24'h00_0006;
    @(posedge clk); #1;
    check("err_clr_priority", {31'h0, bus_error}, 32'h0);
    @(negedge clk); clr = 0; sel = '0;
    @(posedge clk); #1;
    check("err_cleared", {31'h0, bus_error}, 32'h0);
`endif

    // Clear beats enable with an all-ones bus
    @(negedge clk);
    din[2] = 32'hFFFF_FFFF; sel = 24'h00_0004; en0 = 1; en1 = 1; clr = 1;
    #1 check("clr_bus", bus.BusMuxOut, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("clr_r0", q0, 32'h0);
    check("clr_r1", q1, 32'h0);

    // Randomized against the reference model
    @(negedge clk);
    clr = 0; en0 = 0; en1 = 0; sel = '0;
    m_q0 = 32'h0; m_err = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int i = 0; i < 24; i++) din[i] = $urandom;
      case ($urandom_range(0, 3))
        0:       sel = '0;
        1:       sel = 24'(1) << $urandom_range(0, 23);
        2:       sel = 24'($urandom) & 24'($urandom) & 24'($urandom);
        default: sel = 24'($urandom);
      endcase
      en0 = 1'($urandom_range(0, 1));
      #1 check("rand_bus", bus.BusMuxOut, model_bus(sel));
      if (en0) m_q0 = model_bus(sel);
      m_err = m_err | model_multi(sel);
      @(posedge clk); #1;
      check("rand_r0", q0, m_q0);
`ifdef BUS_ERR_EN
      check("rand_err", {31'h0, bus_error}, {31'h0, m_err});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
